poly_sq_collect: RTL

//  Downstream of the Sq coefficient serializer (13-bit coefficient per cycle).

---
 rtl/poly_sq_collect_if.sv | 24 ++
 rtl/poly_sq_collect.sv | 116 +++++++++++
 2 files changed

// File: rtl/poly_sq_collect_if.sv
// Stream-in / packed-result bundle between the Sq serializer, the collector
// and the next KEM stage.
interface poly_sq_collect_if #(
  parameter int N    = 701,
  parameter int LOGQ = 13
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [LOGQ-1:0]   in_coef;
  logic              busy;
  logic              done;
  logic [N*LOGQ:1]   poly_out;

  modport master (
    output start, in_valid, in_coef,
    input  in_ready, busy, done, poly_out
  );

  modport slave (
    input  start, in_valid, in_coef,
    output in_ready, busy, done, poly_out
  );
endinterface

// File: rtl/poly_sq_collect.sv
// Collects N streamed LOGQ-bit coefficients into a packed polynomial and
// optionally reduces it mod Phi_n by subtracting c_{N-1} from every slot.
module poly_sq_collect #(
  parameter int N         = 701,
  parameter int LOGQ      = 13,
  parameter int SQ_REDUCE = 1
) (
  input logic              clk,
  input logic              rst_n,
  poly_sq_collect_if.slave bus
);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    REDUCE  = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     count_reg, count_next;
  logic [LOGQ-1:0]   c_last_reg, c_last_next;

  logic              accept;
  logic              count_last;
  logic              slot_we;
  logic [LOGQ-1:0]   cur_slot;
  logic [LOGQ-1:0]   wr_data;
  logic [N*LOGQ-1:0] slots_flat;

  assign accept     = (state_reg == COLLECT) && bus.in_valid;
  assign count_last = (count_reg == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      c_last_reg <= '0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      c_last_reg <= c_last_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    c_last_next = c_last_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = COLLECT;
          count_next = '0;
        end
      end
      COLLECT: begin
        if (accept) begin
          if (count_last) begin
            // count wraps to 0 here so it never exceeds N-1 and REDUCE starts at slot 0
            count_next = '0;
            if (SQ_REDUCE != 0) begin
              state_next  = REDUCE;
              c_last_next = bus.in_coef;
            end else begin
              state_next = DONE;
            end
          end else begin
            count_next = count_reg + 1'b1;
          end
        end
      end
      REDUCE: begin
        if (count_last) begin
          state_next = DONE;
          count_next = '0;
        end else begin
          count_next = count_reg + 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // One shared read port and subtractor; only the addressed slot is written.
  assign cur_slot = slots_flat[int'(count_reg) * LOGQ +: LOGQ];
  assign wr_data  = (state_reg == COLLECT) ? bus.in_coef : (cur_slot - c_last_reg);
  assign slot_we  = accept || (state_reg == REDUCE);

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slot
      logic [LOGQ-1:0] slot_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          slot_reg <= '0;
        end else if (slot_we && (count_reg == CW'(gi))) begin
          slot_reg <= wr_data;
        end
      end

      assign slots_flat[gi*LOGQ +: LOGQ] = slot_reg;
    end
  endgenerate

  assign bus.poly_out = slots_flat;
  assign bus.in_ready = (state_reg == COLLECT);
  assign bus.busy     = (state_reg == COLLECT) || (state_reg == REDUCE);
  assign bus.done     = (state_reg == DONE);
endmodule
